// File: rtl/alu_seq.sv
// Sequential 8-op ALU with valid/ready handshake on both sides.
// Logic/arithmetic ops finish on the accept edge; shifts iterate one bit per clock.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             bflag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [SHW-1:0]   cnt;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_v;
  logic             res_b;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic [SHW-1:0]   s;
  logic             is_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = b[SHW-1:0];
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);

  // Single-edge result path; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    bx    = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    res_y = a;
    res_c = 1'b0;
    res_v = 1'b0;
    res_b = 1'b0;
    case (op)
      OP_ADD: begin
        res_y = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = ovf;
      end
      OP_SUB: begin
        res_y = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = ovf;
        res_b = ~sum[WIDTH];
      end
      OP_AND:  res_y = a & b;
      OP_OR:   res_y = a | b;
      OP_XOR:  res_y = a ^ b;
      default: res_y = a;
    endcase
  end

  // One-bit shift step applied to the shift register while BUSY.
  always_comb begin
    sh_next = {sh[WIDTH-2:0], 1'b0};
    sh_out  = sh[WIDTH-1];
    case (op_q)
      OP_SHR: begin
        sh_next = {1'b0, sh[WIDTH-1:1]};
        sh_out  = sh[0];
      end
      OP_ASR: begin
        sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]};
        sh_out  = sh[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      op_q  <= OP_ADD;
      y     <= '0;
      z     <= 1'b0;
      n     <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
      bflag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (s != '0)) begin
              sh    <= a;
              cnt   <= s;
              op_q  <= op;
              state <= BUSY;
            end else begin
              y     <= res_y;
              z     <= (res_y == '0);
              n     <= res_y[WIDTH-1];
              c     <= res_c;
              v     <= res_v;
              bflag <= res_b;
              state <= DONE;
            end
          end
        end
        BUSY: begin
          sh  <= sh_next;
          cnt <= cnt - SHW'(1);
          // Result and flags stay frozen until the last shift lands.
          if (cnt == SHW'(1)) begin
            y     <= sh_next;
            z     <= (sh_next == '0);
            n     <= sh_next[WIDTH-1];
            c     <= sh_out;
            v     <= 1'b0;
            bflag <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed requests push hand-computed results,
// an independent monitor pops and compares each time out_valid rises.
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] SHR = 3'b110;
  localparam logic [2:0] ASR = 3'b111;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       z, n, c, v, bflag;
  logic [4:0] flags;

  typedef struct {
    logic [7:0] y;
    logic [4:0] f;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nres = 0;
  int   npushed = 0;
  logic prev_ov = 1'b0;
  int   acc1, acc2;

  assign flags = {z, n, c, v, bflag};

  alu_seq #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .z(z), .n(n), .c(c), .v(v), .bflag(bflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: compares each newly presented result against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov <= 1'b0;
    end else begin
      prev_ov <= out_valid;
      if (out_valid && !prev_ov) begin
        nres <= nres + 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output y=%0h", y);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("res%0d_y", nres), 32'(y), 32'(e.y));
          checkOutput($sformatf("res%0d_flags", nres), 32'(flags), 32'(e.f));
          checkOutput($sformatf("res%0d_latency", nres), 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  // Drives one request and holds it until accepted; records the accept cycle.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [7:0] ey, input logic [4:0] ef, input int lat,
                               input bit expect_out, output int acc_cyc);
    bit accepted = 0;
    bit rdy;
    acc_cyc = 0;
    @(negedge clk);
    a = ia;
    b = ib;
    op = o;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout got=0 expected=1");
    end else begin
      acc_cyc = cyc;
      if (expect_out) begin
        sb.push_back('{ey, ef, lat, cyc});
        npushed++;
      end
    end
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready && !out_valid) begin
        idle = 1;
        break;
      end
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout got=0 expected=1");
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = ADD;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_y", 32'(y), 32'h00);
    checkOutput("rst_flags", 32'(flags), 32'h00);
    rst = 1'b0;

    applyStimulus(ADD, 8'hFF, 8'h01, 8'h00, 5'b10100, 1, 1, acc1);
    waitIdle();
    applyStimulus(SUB, 8'h80, 8'h01, 8'h7F, 5'b00110, 1, 1, acc1);
    waitIdle();
    applyStimulus(SUB, 8'h00, 8'h01, 8'hFF, 5'b01001, 1, 1, acc1);
    waitIdle();
    applyStimulus(ADD, 8'h7F, 8'h01, 8'h80, 5'b01010, 1, 1, acc1);
    waitIdle();
    applyStimulus(SHL, 8'h81, 8'h01, 8'h02, 5'b00100, 2, 1, acc1);
    waitIdle();
    applyStimulus(SHR, 8'h81, 8'h01, 8'h40, 5'b00100, 2, 1, acc1);
    waitIdle();

    // Longest shift: ready must stay low for the whole operation.
    applyStimulus(ASR, 8'h90, 8'h07, 8'hFF, 5'b01000, 8, 1, acc1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput($sformatf("asr_busy_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    waitIdle();
    applyStimulus(SHR, 8'h5A, 8'h00, 8'h5A, 5'b00000, 1, 1, acc1);
    waitIdle();

    // Consumer stalls; a stray request during DONE must be ignored.
    out_ready = 1'b0;
    applyStimulus(XOR, 8'hF0, 8'hFF, 8'h0F, 5'b00000, 1, 1, acc1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d_y", i), 32'(y), 32'h0F);
      checkOutput($sformatf("hold%0d_flags", i), 32'(flags), 32'h00);
      checkOutput($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      if (i == 2) begin
        a = 8'h01;
        b = 8'h01;
        op = ADD;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    waitIdle();

    applyStimulus(ADD, 8'h12, 8'h34, 8'h46, 5'b00000, 1, 1, acc1);
    applyStimulus(AND, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1, 1, acc2);
    checkOutput("b2b_spacing", 32'(acc2 - acc1), 32'd2);
    waitIdle();

    // Reset in the middle of a long shift aborts it without a result.
    applyStimulus(SHR, 8'hFF, 8'h07, 8'h00, 5'b00000, 0, 0, acc1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_y", 32'(y), 32'h00);
    checkOutput("abort_flags", 32'(flags), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    checkOutput("abort_no_result", 32'(out_valid), 32'd0);

    applyStimulus(OR, 8'h00, 8'h00, 8'h00, 5'b10000, 1, 1, acc1);
    waitIdle();

    checkOutput("output_count", 32'(nres), 32'(npushed));
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
